// File: rtl/wb_arbiter_if.sv
// Register-file write-port bundle between the pipeline/long unit and wb_arbiter.
// Perf counter signals exist only when WB_ARBITER_PERF_EN is defined.
interface wb_arbiter_if;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        LValid;
  logic [4:0]  LReg;
  logic [31:0] LData;
  logic        LReady;
  logic        IssueE;
  logic [4:0]  IssueRegE;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        PendA1;
  logic        PendA2;
  logic        StallReqW;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
`ifdef WB_ARBITER_PERF_EN
  logic [31:0] PerfConflict;
  logic [31:0] PerfStall;
`endif

  modport slave (
    input  RegWriteW, WriteRegW, ResultW, LValid, LReg, LData,
           IssueE, IssueRegE, A1, A2,
    output LReady, PendA1, PendA2, StallReqW, WE3, A3, WD3
`ifdef WB_ARBITER_PERF_EN
    , output PerfConflict, PerfStall
`endif
  );

  modport master (
    output RegWriteW, WriteRegW, ResultW, LValid, LReg, LData,
           IssueE, IssueRegE, A1, A2,
    input  LReady, PendA1, PendA2, StallReqW, WE3, A3, WD3
`ifdef WB_ARBITER_PERF_EN
    , input PerfConflict, PerfStall
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: main writeback wins, long results queue and drain when idle.
// Optional conflict/stall counters are enabled with WB_ARBITER_PERF_EN.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sb_q, sb_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic   main_active, empty, full, accept, push, pop, starved;
  entry_t head;

  // NOTE: every signal is assigned a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    main_active = bus.RegWriteW && (bus.WriteRegW != 5'd0);
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    starved     = (starve_q == STV_W'(STARVE_MAX));
    head        = fifo_q[rd_ptr_q];
    accept      = bus.LValid && !full && !rst;
    push        = accept && (bus.LReg != 5'd0);
    pop         = !rst && !main_active && !empty;

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Issue is applied after the pop clear so a same-cycle set wins.
    sb_d = sb_q;
    if (pop) sb_d[head.rd] = 1'b0;
    if (bus.IssueE && (bus.IssueRegE != 5'd0)) sb_d[bus.IssueRegE] = 1'b1;
    sb_d[0] = 1'b0;

    if (pop || empty)                starve_d = '0;
    else if (main_active && !starved) starve_d = starve_q + STV_W'(1);
    else                             starve_d = starve_q;
  end

  always_comb begin
    bus.WE3 = 1'b0;
    bus.A3  = '0;
    bus.WD3 = '0;
    if (!rst) begin
      if (main_active) begin
        bus.WE3 = 1'b1;
        bus.A3  = bus.WriteRegW;
        bus.WD3 = bus.ResultW;
      end else if (!empty) begin
        bus.WE3 = 1'b1;
        bus.A3  = head.rd;
        bus.WD3 = head.data;
      end
    end
    bus.LReady    = !full && !rst;
    bus.StallReqW = starved && !rst;
    bus.PendA1    = sb_q[bus.A1];
    bus.PendA2    = sb_q[bus.A2];
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sb_q     <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sb_q     <= sb_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: storage is not reset; only entries covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: bus.LReg, data: bus.LData};
  end

`ifdef WB_ARBITER_PERF_EN
  logic [31:0] perf_conflict_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      if (main_active && !empty) perf_conflict_q <= perf_conflict_q + 32'd1;
      if (starved)               perf_stall_q    <= perf_stall_q + 32'd1;
    end
  end

  assign bus.PerfConflict = perf_conflict_q;
  assign bus.PerfStall    = perf_stall_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-level reference model checked every cycle plus literal spot checks.
module tb_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of pending results, a bit-set of pending registers, a starve count.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] msb;
  int          mstarve;
  int          mperf_conflict;
  int          mperf_stall;

  initial begin
    logic main, pop, acc;
    int   size;
    msb = '0; mstarve = 0; mperf_conflict = 0; mperf_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("m_rst_we3", 32'(bus.WE3), 32'd0);
        check("m_rst_lready", 32'(bus.LReady), 32'd0);
        check("m_rst_stall", 32'(bus.StallReqW), 32'd0);
        check("m_rst_a3", 32'(bus.A3), 32'd0);
        check("m_rst_wd3", bus.WD3, 32'd0);
        mq.delete();
        msb = '0; mstarve = 0; mperf_conflict = 0; mperf_stall = 0;
      end else begin
        size = mq.size();
        main = bus.RegWriteW && (bus.WriteRegW != 5'd0);
        pop  = !main && (size > 0);
        acc  = bus.LValid && (size < DEPTH);

        check("m_lready", 32'(bus.LReady), 32'(size < DEPTH));
        check("m_stall", 32'(bus.StallReqW), 32'(mstarve == STARVE_MAX));
        check("m_penda1", 32'(bus.PendA1), 32'(msb[bus.A1]));
        check("m_penda2", 32'(bus.PendA2), 32'(msb[bus.A2]));
        if (main) begin
          check("m_we3", 32'(bus.WE3), 32'd1);
          check("m_a3_main", 32'(bus.A3), 32'(bus.WriteRegW));
          check("m_wd3_main", bus.WD3, bus.ResultW);
        end else if (size > 0) begin
          check("m_we3", 32'(bus.WE3), 32'd1);
          check("m_a3_fifo", 32'(bus.A3), 32'(mq[0].rd));
          check("m_wd3_fifo", bus.WD3, mq[0].data);
        end else begin
          check("m_we3", 32'(bus.WE3), 32'd0);
        end
`ifdef WB_ARBITER_PERF_EN
        check("m_perf_conflict", bus.PerfConflict, 32'(mperf_conflict));
        check("m_perf_stall", bus.PerfStall, 32'(mperf_stall));
`endif
        if (main && size > 0) mperf_conflict++;
        if (mstarve == STARVE_MAX) mperf_stall++;

        if (pop) msb[mq[0].rd] = 1'b0;
        if (bus.IssueE && bus.IssueRegE != 5'd0) msb[bus.IssueRegE] = 1'b1;
        msb[0] = 1'b0;

        if (pop || size == 0)                mstarve = 0;
        else if (main && mstarve < STARVE_MAX) mstarve++;

        if (pop) void'(mq.pop_front());
        if (acc && bus.LReg != 5'd0) mq.push_back('{rd: bus.LReg, data: bus.LData});
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.RegWriteW = 1'b0; bus.WriteRegW = '0; bus.ResultW = '0;
    bus.LValid    = 1'b0; bus.LReg      = '0; bus.LData   = '0;
    bus.IssueE    = 1'b0; bus.IssueRegE = '0;
    bus.A1        = '0;   bus.A2        = '0;
    repeat (2) cyc();
    check("rst_we3", 32'(bus.WE3), 32'd0);
    check("rst_lready", 32'(bus.LReady), 32'd0);
    check("rst_stall", 32'(bus.StallReqW), 32'd0);

    // Main write wins at zero latency.
    rst = 1'b0;
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd5; bus.ResultW = 32'h1234; bus.A1 = 5'd5;
    #1;
    check("main_we3", 32'(bus.WE3), 32'd1);
    check("main_a3", 32'(bus.A3), 32'd5);
    check("main_wd3", bus.WD3, 32'h1234);
    check("main_lready", 32'(bus.LReady), 32'd1);
    check("main_penda1", 32'(bus.PendA1), 32'd0);
    cyc();

    // Issue reg 9, result arrives two cycles later, lands one cycle after accept.
    bus.RegWriteW = 1'b0; bus.IssueE = 1'b1; bus.IssueRegE = 5'd9; bus.A1 = 5'd9;
    #1 check("iss_pend_before", 32'(bus.PendA1), 32'd0);
    cyc();
    bus.IssueE = 1'b0;
    #1 check("iss_pend_set", 32'(bus.PendA1), 32'd1);
    cyc();
    bus.LValid = 1'b1; bus.LReg = 5'd9; bus.LData = 32'hDEADBEEF;
    #1;
    check("long_lready", 32'(bus.LReady), 32'd1);
    check("long_no_bypass", 32'(bus.WE3), 32'd0);
    cyc();
    bus.LValid = 1'b0;
    #1;
    check("long_we3", 32'(bus.WE3), 32'd1);
    check("long_a3", 32'(bus.A3), 32'd9);
    check("long_wd3", bus.WD3, 32'hDEADBEEF);
    check("long_pend_popcyc", 32'(bus.PendA1), 32'd1);
    cyc();
    check("long_pend_clear", 32'(bus.PendA1), 32'd0);
    check("long_idle_we3", 32'(bus.WE3), 32'd0);

    // Main writes every cycle while four results queue; starvation forces a stall.
    for (int i = 0; i < 9; i++) begin
      bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd20; bus.ResultW = 32'(i);
      bus.LValid = (i < 4); bus.LReg = 5'(10 + i); bus.LData = 32'hA0 + 32'(i);
      #1;
      if (i == 4) check("full_lready", 32'(bus.LReady), 32'd0);
      check("starve_no_stall", 32'(bus.StallReqW), 32'd0);
      check("starve_main_a3", 32'(bus.A3), 32'd20);
      cyc();
    end
    bus.RegWriteW = 1'b0; bus.LValid = 1'b0;
    #1;
    check("stall_req", 32'(bus.StallReqW), 32'd1);
    check("stall_pop_a3", 32'(bus.A3), 32'd10);
    check("stall_pop_wd3", bus.WD3, 32'hA0);
    check("stall_full_lready", 32'(bus.LReady), 32'd0);
    cyc();
    check("after_pop_lready", 32'(bus.LReady), 32'd1);
    check("after_pop_stall", 32'(bus.StallReqW), 32'd0);
    check("drain_a3_11", 32'(bus.A3), 32'd11);
    cyc();
    check("drain_a3_12", 32'(bus.A3), 32'd12);
    cyc();
    check("drain_a3_13", 32'(bus.A3), 32'd13);
    cyc();
    check("drain_done", 32'(bus.WE3), 32'd0);

    // Result for r0 is accepted and dropped.
    bus.LValid = 1'b1; bus.LReg = 5'd0; bus.LData = 32'hFFFFFFFF;
    #1 check("r0_lready", 32'(bus.LReady), 32'd1);
    cyc();
    bus.LValid = 1'b0;
    #1 check("r0_no_write", 32'(bus.WE3), 32'd0);
    cyc();

    // Re-issue of reg 3 in its own pop cycle keeps the pending bit.
    bus.IssueE = 1'b1; bus.IssueRegE = 5'd3; bus.A1 = 5'd3;
    cyc();
    bus.IssueE = 1'b0; bus.LValid = 1'b1; bus.LReg = 5'd3; bus.LData = 32'h33;
    #1 check("r3_pend", 32'(bus.PendA1), 32'd1);
    cyc();
    bus.LValid = 1'b0; bus.IssueE = 1'b1; bus.IssueRegE = 5'd3;
    #1;
    check("r3_pop_we3", 32'(bus.WE3), 32'd1);
    check("r3_pop_a3", 32'(bus.A3), 32'd3);
    check("r3_pop_wd3", bus.WD3, 32'h33);
    cyc();
    bus.IssueE = 1'b0;
    #1;
    check("r3_set_wins", 32'(bus.PendA1), 32'd1);
    check("r3_idle", 32'(bus.WE3), 32'd0);

    // Queue three results behind main writes, then reset mid-flight.
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd1; bus.ResultW = 32'h55;
    bus.IssueE = 1'b1; bus.IssueRegE = 5'd7;
    bus.LValid = 1'b1; bus.LReg = 5'd3; bus.LData = 32'h103;
    cyc();
    bus.IssueE = 1'b0; bus.LReg = 5'd7; bus.LData = 32'h107;
    cyc();
    bus.LReg = 5'd15; bus.LData = 32'h10F; bus.A1 = 5'd3; bus.A2 = 5'd7;
    #1;
    check("pre_rst_pend3", 32'(bus.PendA1), 32'd1);
    check("pre_rst_pend7", 32'(bus.PendA2), 32'd1);
    cyc();
    bus.LValid = 1'b0; bus.RegWriteW = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_we3", 32'(bus.WE3), 32'd0);
    check("mid_rst_lready", 32'(bus.LReady), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_we3", 32'(bus.WE3), 32'd0);
    check("post_rst_lready", 32'(bus.LReady), 32'd1);
    check("post_rst_pend3", 32'(bus.PendA1), 32'd0);
    check("post_rst_pend7", 32'(bus.PendA2), 32'd0);
    bus.A1 = 5'd7;
    #1 check("post_rst_pend7_a1", 32'(bus.PendA1), 32'd0);
    cyc();
    check("post_rst_no_drain", 32'(bus.WE3), 32'd0);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the register-file write port (WE3/A3/WD3).
- Merges the in-order pipeline's writeback with results returned later by a long-latency unit (mul/div or external).
- Long results wait in a small FIFO and drain only in cycles where the main pipeline is not writing.
- A pending-register scoreboard lets the hazard unit stall decode on reads of registers whose long result has not landed yet.

Parameters:
- DEPTH, 4, FIFO entries for long results; power of two, min 2.
- STARVE_MAX, 8, consecutive lost-arbitration cycles before StallReqW asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- RegWriteW  in  1  main pipeline writes this cycle.
- WriteRegW  in  5  main destination register.
- ResultW  in  32  main write data.
- LValid  in  1  long unit offers a result.
- LReg  in  5  long result destination.
- LData  in  32  long result data.
- LReady  out  1  arbiter accepts the long result this cycle.
- IssueE  in  1  long op issued this cycle (sets scoreboard).
- IssueRegE  in  5  destination of the issued long op.
- A1  in  5  decode read address 1.
- A2  in  5  decode read address 2.
- PendA1  out  1  A1 has an outstanding long result.
- PendA2  out  1  A2 has an outstanding long result.
- StallReqW  out  1  request to freeze the main pipeline for one cycle.
- WE3  out  1  register-file write enable.
- A3  out  5  register-file write address.
- WD3  out  32  register-file write data.

Behaviour:
- Reset (rst high at posedge):
  - FIFO emptied; scoreboard cleared; starve counter = 0.
  - While rst is high: WE3=0, LReady=0, StallReqW=0. A3/WD3 are don't-care but driven 0.
- Main write is "active" when RegWriteW=1 and WriteRegW!=0.
- Priority: an active main write always wins, at zero latency: WE3=1, A3=WriteRegW, WD3=ResultW, all combinational from inputs.
- FIFO drain: when no main write is active and the FIFO is non-empty, drive WE3=1, A3=head.reg, WD3=head.data, and pop at the edge.
- Otherwise WE3=0.
- LReady = !full (combinational).
- Accept = LValid & LReady:
  - Accepted with LReg!=0: enqueue at the edge.
  - Accepted with LReg==0: consumed and discarded, not enqueued.
- FIFO full with a pop in the same cycle: LReady stays 0; no combined push/pop through a full FIFO.
- FIFO empty: no bypass from LValid straight to WE3. A result always spends at least one cycle in the FIFO, so long-result latency is 1 cycle minimum.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy is kept in a counter of width log2(DEPTH)+1.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - IssueE with IssueRegE!=0 sets bit[IssueRegE].
  - A FIFO pop clears bit[head.reg].
  - Set and clear of the same register in the same cycle: set wins.
  - A main-pipeline write never clears a bit.
  - PendA1 = sb[A1], PendA2 = sb[A2], combinational.
  - Reset mid-flight discards queued results and pending bits.
- Starve counter:
  - Increments when the FIFO is non-empty and a main write is active.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - StallReqW = (count==STARVE_MAX), registered.
  - While StallReqW=1 the pipeline is frozen with RegWriteW=0, so the next cycle pops and the counter clears.

Optional Feature:
- Macro: WB_ARBITER_PERF_EN.
- Defined:
  - Adds output PerfConflict[31:0]: counts cycles where a main write is active and the FIFO is non-empty.
  - Adds output PerfStall[31:0]: counts cycles with StallReqW=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset, then RegWriteW=1, WriteRegW=5, ResultW=0x1234 -> same cycle WE3=1, A3=5, WD3=0x1234; LReady=1; PendA1=0 with A1=5.
- IssueE=1, IssueRegE=9; two cycles later LValid=1, LReg=9, LData=0xDEADBEEF; main idle -> PendA1=1 (A1=9) until the pop cycle; write lands one cycle after acceptance with A3=9; PendA1=0 after that edge.
- Main writes every cycle while 4 long results arrive (DEPTH=4) -> LReady=0 after the 4th accept; StallReqW=1 after 8 conflict cycles; the next idle cycle pops the head and LReady returns to 1.
- LValid=1, LReg=0, LData=0xFFFFFFFF -> accepted (LReady=1), FIFO occupancy stays 0, no WE3 from it.
- IssueE=1, IssueRegE=3 in the same cycle a queued result for reg 3 pops -> WE3=1 with A3=3, and sb[3] stays 1 after the edge.
- Assert rst for one cycle with 3 queued results and sb[3,7] set -> next cycle WE3=0, LReady=1, PendA1=0 for A1=3 and A1=7, queued data never written.
